// File: rtl/hssi_rst_pkg.sv
// Shared types and sizing helpers for the HSSI reset responder.
// The lane state encoding is also exported so the parent can detect all-lanes-acked.
package hssi_rst_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        ACKED    = 2'd2,
        WAIT_RDY = 2'd3
    } rst_lane_state_t;

    localparam int DEF_HOLD_CYC    = 32;
    localparam int DEF_TIMEOUT_CYC = 4096;

    // One counter serves both hold and ready-timeout, so it is sized for the larger.
    function automatic int cnt_width(input int hold_cyc, input int timeout_cyc);
        int m;
        m = (hold_cyc > timeout_cyc) ? hold_cyc : timeout_cyc;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/hssi_rst_responder_if.sv
// Reset request/ack bundle between the HSSI wrapper CSRs and the reset responder.
// master = requester side (CSR block), slave = responder.
interface hssi_rst_responder_if #(
    parameter int NUM_CH = 16
);
    logic [NUM_CH-1:0] i_tx_rst;
    logic [NUM_CH-1:0] i_rx_rst;
    logic              i_cold_rst;
    logic [NUM_CH-1:0] i_tx_ready;
    logic [NUM_CH-1:0] i_rx_ready;
    logic [NUM_CH-1:0] o_tx_rst_ack;
    logic [NUM_CH-1:0] o_rx_rst_ack;
    logic              o_cold_rst_ack;
    logic [NUM_CH-1:0] o_tx_reset;
    logic [NUM_CH-1:0] o_rx_reset;
    logic [NUM_CH-1:0] o_tx_timeout;
    logic [NUM_CH-1:0] o_rx_timeout;

    modport master (
        output i_tx_rst, i_rx_rst, i_cold_rst, i_tx_ready, i_rx_ready,
        input  o_tx_rst_ack, o_rx_rst_ack, o_cold_rst_ack,
        input  o_tx_reset, o_rx_reset, o_tx_timeout, o_rx_timeout
    );

    modport slave (
        input  i_tx_rst, i_rx_rst, i_cold_rst, i_tx_ready, i_rx_ready,
        output o_tx_rst_ack, o_rx_rst_ack, o_cold_rst_ack,
        output o_tx_reset, o_rx_reset, o_tx_timeout, o_rx_timeout
    );
endinterface

// File: rtl/hssi_rst_lane_fsm.sv
// One lane of the reset handshake: hold reset >= HOLD_CYC, then wait for synchronized ready.
// Outputs decode directly from the state register; reset follows req by one edge.
module hssi_rst_lane_fsm
    import hssi_rst_pkg::*;
#(
    parameter int HOLD_CYC    = DEF_HOLD_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_i,
    input  logic            ready_async_i,
    output logic            reset_o,
    output logic            ack_o,
    output logic            timeout_o,
    output rst_lane_state_t state_o
);
    localparam int            CW        = cnt_width(HOLD_CYC, TIMEOUT_CYC);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYC - 1);

    rst_lane_state_t state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            timeout_q, timeout_d;
    logic            rdy_meta_q, rdy_sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
            rdy_meta_q <= 1'b0;
            rdy_sync_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
            rdy_meta_q <= ready_async_i;
            rdy_sync_q <= rdy_meta_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    state_d   = HOLD;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            // Request is ignored here: the hold time always runs to completion.
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ACKED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ACKED: begin
                if (!req_i) begin
                    state_d = WAIT_RDY;
                    cnt_d   = '0;
                end
            end
            WAIT_RDY: begin
                if (req_i) begin
                    state_d   = HOLD;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                end else if (rdy_sync_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign reset_o   = (state_q == HOLD) || (state_q == ACKED);
    assign ack_o     = (state_q == ACKED) || (state_q == WAIT_RDY);
    assign timeout_o = timeout_q;
    assign state_o   = state_q;

endmodule

// File: rtl/hssi_rst_responder.sv
// HSSI per-channel reset responder: 2*NUM_CH lane FSMs plus the cold-reset acknowledge.
// Cold ack registers one edge after every lane is in ACKED and drops one edge after cold clears.
module hssi_rst_responder
    import hssi_rst_pkg::*;
#(
    parameter int NUM_CH      = 16,
    parameter int HOLD_CYC    = DEF_HOLD_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hssi_rst_responder_if.slave  bus
);
    localparam int NLANE = 2 * NUM_CH;

    // Lanes [NUM_CH-1:0] are TX, [NLANE-1:NUM_CH] are RX.
    logic [NLANE-1:0] lane_req;
    logic [NLANE-1:0] lane_rdy;
    logic [NLANE-1:0] lane_reset;
    logic [NLANE-1:0] lane_ack;
    logic [NLANE-1:0] lane_to;
    logic [NLANE-1:0] lane_acked;
    logic             cold_ack_q, cold_ack_d;

    assign lane_req = {bus.i_rx_rst, bus.i_tx_rst} | {NLANE{bus.i_cold_rst}};
    assign lane_rdy = {bus.i_rx_ready, bus.i_tx_ready};

    for (genvar g = 0; g < NLANE; g++) begin : g_lane
        rst_lane_state_t lane_state;

        hssi_rst_lane_fsm #(
            .HOLD_CYC    (HOLD_CYC),
            .TIMEOUT_CYC (TIMEOUT_CYC)
        ) u_lane (
            .clk           (clk),
            .rst_n         (rst_n),
            .req_i         (lane_req[g]),
            .ready_async_i (lane_rdy[g]),
            .reset_o       (lane_reset[g]),
            .ack_o         (lane_ack[g]),
            .timeout_o     (lane_to[g]),
            .state_o       (lane_state)
        );

        assign lane_acked[g] = (lane_state == ACKED);
    end

    assign cold_ack_d = bus.i_cold_rst & (&lane_acked);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cold_ack_q <= 1'b0;
        end else begin
            cold_ack_q <= cold_ack_d;
        end
    end

    assign bus.o_tx_reset     = lane_reset[NUM_CH-1:0];
    assign bus.o_rx_reset     = lane_reset[NLANE-1:NUM_CH];
    assign bus.o_tx_rst_ack   = lane_ack[NUM_CH-1:0];
    assign bus.o_rx_rst_ack   = lane_ack[NLANE-1:NUM_CH];
    assign bus.o_tx_timeout   = lane_to[NUM_CH-1:0];
    assign bus.o_rx_timeout   = lane_to[NLANE-1:NUM_CH];
    assign bus.o_cold_rst_ack = cold_ack_q;

endmodule

// File: tb/tb_hssi_rst_responder.sv
// Bench for hssi_rst_responder: directed handshake scenarios, then randomized traffic
// compared every cycle against a timer-based reference model of each lane.
module tb_hssi_rst_responder;
    localparam int NC = 16;
    localparam int H  = 32;
    localparam int T  = 128;
    localparam int NL = 2 * NC;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hssi_rst_responder_if #(.NUM_CH(NC)) bus ();

    hssi_rst_responder #(
        .NUM_CH      (NC),
        .HOLD_CYC    (H),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: per lane, remaining hold time, reset-applied flag,
    // age since release (-1 = not waiting), sticky timeout, and a 2-edge ready delay.
    int hold_left [NL];
    bit applied   [NL];
    int wait_age  [NL];
    bit to_flag   [NL];
    bit rdy_d1    [NL];
    bit rdy_d2    [NL];
    bit m_cold_ack;

    function automatic bit lane_req(input int l);
        return ((l < NC) ? bus.i_tx_rst[l] : bus.i_rx_rst[l-NC]) | bus.i_cold_rst;
    endfunction

    function automatic bit lane_ready(input int l);
        return (l < NC) ? bus.i_tx_ready[l] : bus.i_rx_ready[l-NC];
    endfunction

    function automatic bit m_rst(input int l);
        return (hold_left[l] > 0) || applied[l];
    endfunction

    function automatic bit m_ack(input int l);
        return applied[l] || (wait_age[l] >= 0);
    endfunction

    task automatic model_clear();
        for (int l = 0; l < NL; l++) begin
            hold_left[l] = 0;
            applied[l]   = 1'b0;
            wait_age[l]  = -1;
            to_flag[l]   = 1'b0;
            rdy_d1[l]    = 1'b0;
            rdy_d2[l]    = 1'b0;
        end
        m_cold_ack = 1'b0;
    endtask

    task automatic model_step();
        bit all_app;
        bit req;
        bit seen;
        all_app = 1'b1;
        if (!rst_n) begin
            model_clear();
            return;
        end
        for (int l = 0; l < NL; l++) all_app &= applied[l];
        m_cold_ack = bus.i_cold_rst && all_app;
        for (int l = 0; l < NL; l++) begin
            req       = lane_req(l);
            seen      = rdy_d2[l];
            rdy_d2[l] = rdy_d1[l];
            rdy_d1[l] = lane_ready(l);
            if (hold_left[l] > 0) begin
                hold_left[l]--;
                if (hold_left[l] == 0) applied[l] = 1'b1;
            end else if (applied[l]) begin
                if (!req) begin
                    applied[l]  = 1'b0;
                    wait_age[l] = 0;
                end
            end else if (wait_age[l] >= 0) begin
                if (req) begin
                    wait_age[l]  = -1;
                    hold_left[l] = H;
                    to_flag[l]   = 1'b0;
                end else if (seen) begin
                    wait_age[l] = -1;
                end else if (wait_age[l] == T - 1) begin
                    wait_age[l] = -1;
                    to_flag[l]  = 1'b1;
                end else begin
                    wait_age[l]++;
                end
            end else if (req) begin
                hold_left[l] = H;
                to_flag[l]   = 1'b0;
            end
        end
    endtask

    function automatic logic [NC-1:0] exp_vec(input int kind, input int dir);
        logic [NC-1:0] v;
        v = '0;
        for (int c = 0; c < NC; c++) begin
            case (kind)
                0:       v[c] = m_rst(c + dir * NC);
                1:       v[c] = m_ack(c + dir * NC);
                default: v[c] = to_flag[c + dir * NC];
            endcase
        end
        return v;
    endfunction

    task automatic compare_model();
        check("m_tx_reset",   64'(bus.o_tx_reset),     64'(exp_vec(0, 0)));
        check("m_rx_reset",   64'(bus.o_rx_reset),     64'(exp_vec(0, 1)));
        check("m_tx_ack",     64'(bus.o_tx_rst_ack),   64'(exp_vec(1, 0)));
        check("m_rx_ack",     64'(bus.o_rx_rst_ack),   64'(exp_vec(1, 1)));
        check("m_tx_timeout", 64'(bus.o_tx_timeout),   64'(exp_vec(2, 0)));
        check("m_rx_timeout", 64'(bus.o_rx_timeout),   64'(exp_vec(2, 1)));
        check("m_cold_ack",   64'(bus.o_cold_rst_ack), 64'(m_cold_ack));
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            #1;
            compare_model();
        end
    endtask

    task automatic drain();
        bus.i_tx_rst   = '0;
        bus.i_rx_rst   = '0;
        bus.i_cold_rst = 1'b0;
        bus.i_tx_ready = '1;
        bus.i_rx_ready = '1;
        tick(4);
        bus.i_tx_ready = '0;
        bus.i_rx_ready = '0;
        tick(1);
    endtask

    task automatic rand_drive(input logic [NL-1:0] dead, inout bit cold_on);
        logic [NC-1:0] tr, rr, ty, ry;
        bit r;
        tr = bus.i_tx_rst;
        rr = bus.i_rx_rst;
        for (int l = 0; l < NL; l++) begin
            r = (l < NC) ? tr[l] : rr[l-NC];
            if (r && applied[l] && $urandom_range(0, 3) == 0) r = 1'b0;
            else if (!r && !m_ack(l) && !m_rst(l) && $urandom_range(0, 59) == 0) r = 1'b1;
            else if (!r && wait_age[l] >= 0 && $urandom_range(0, 199) == 0) r = 1'b1;
            if (l < NC) tr[l] = r; else rr[l-NC] = r;
            if (l < NC) ty[l] = !dead[l] && ($urandom_range(0, 15) == 0);
            else        ry[l-NC] = !dead[l] && ($urandom_range(0, 15) == 0);
        end
        if (cold_on && m_cold_ack && $urandom_range(0, 1) == 0) cold_on = 1'b0;
        else if (!cold_on && $urandom_range(0, 799) == 0) cold_on = 1'b1;
        bus.i_tx_rst   = tr;
        bus.i_rx_rst   = rr;
        bus.i_tx_ready = ty;
        bus.i_rx_ready = ry;
        bus.i_cold_rst = cold_on;
    endtask

    initial begin
        logic [NL-1:0] dead;
        bit cold_on;
        model_clear();
        bus.i_tx_rst   = '0;
        bus.i_rx_rst   = '0;
        bus.i_cold_rst = 1'b0;
        bus.i_tx_ready = '0;
        bus.i_rx_ready = '0;
        rst_n = 1'b0;
        tick(3);
        check("rst_tx_reset", 64'(bus.o_tx_reset), 64'd0);
        check("rst_rx_ack",   64'(bus.o_rx_rst_ack), 64'd0);
        check("rst_cold_ack", 64'(bus.o_cold_rst_ack), 64'd0);
        rst_n = 1'b1;
        tick(5);

        // Single TX request on channel 3.
        bus.i_tx_rst[3] = 1'b1;
        tick(1);
        check("tx3_reset_on", 64'(bus.o_tx_reset), 64'h0008);
        tick(H - 1);
        check("tx3_ack_early", 64'(bus.o_tx_rst_ack), 64'h0000);
        tick(1);
        check("tx3_ack_on", 64'(bus.o_tx_rst_ack), 64'h0008);
        check("tx3_rx_quiet", 64'(bus.o_rx_reset), 64'h0000);
        bus.i_tx_rst[3] = 1'b0;
        tick(1);
        check("tx3_reset_off", 64'(bus.o_tx_reset), 64'h0000);
        bus.i_tx_ready[3] = 1'b1;
        tick(2);
        check("tx3_ack_sync", 64'(bus.o_tx_rst_ack), 64'h0008);
        tick(1);
        check("tx3_ack_off", 64'(bus.o_tx_rst_ack), 64'h0000);
        drain();

        // Ready timeout on RX0.
        bus.i_rx_rst[0] = 1'b1;
        tick(H + 1);
        bus.i_rx_rst[0] = 1'b0;
        tick(1);
        tick(T - 1);
        check("rx0_ack_pre_to", 64'(bus.o_rx_rst_ack), 64'h0001);
        check("rx0_to_pre",     64'(bus.o_rx_timeout), 64'h0000);
        tick(1);
        check("rx0_ack_to",  64'(bus.o_rx_rst_ack), 64'h0000);
        check("rx0_to_set",  64'(bus.o_rx_timeout), 64'h0001);
        tick(3);
        check("rx0_to_sticky", 64'(bus.o_rx_timeout), 64'h0001);
        bus.i_rx_rst[0] = 1'b1;
        tick(1);
        check("rx0_to_clear", 64'(bus.o_rx_timeout), 64'h0000);
        tick(H);
        drain();

        // Cold reset across every lane.
        bus.i_cold_rst = 1'b1;
        tick(1);
        check("cold_tx_reset", 64'(bus.o_tx_reset), 64'hFFFF);
        check("cold_rx_reset", 64'(bus.o_rx_reset), 64'hFFFF);
        tick(H);
        check("cold_acks",      64'({bus.o_rx_rst_ack, bus.o_tx_rst_ack}), 64'hFFFF_FFFF);
        check("cold_ack_early", 64'(bus.o_cold_rst_ack), 64'd0);
        tick(1);
        check("cold_ack_on", 64'(bus.o_cold_rst_ack), 64'd1);
        bus.i_cold_rst = 1'b0;
        tick(1);
        check("cold_ack_off", 64'(bus.o_cold_rst_ack), 64'd0);
        drain();

        // Early drop on TX5, then re-request from WAIT_RDY.
        bus.i_tx_rst[5] = 1'b1;
        tick(5);
        bus.i_tx_rst[5] = 1'b0;
        tick(H - 5);
        check("tx5_hold_kept", 64'(bus.o_tx_reset), 64'h0020);
        tick(1);
        check("tx5_ack_pulse", 64'(bus.o_tx_rst_ack), 64'h0020);
        tick(1);
        check("tx5_released", 64'({bus.o_tx_reset, bus.o_tx_rst_ack}), 64'h0000_0020);
        tick(4);
        bus.i_tx_rst[5] = 1'b1;
        tick(1);
        check("tx5_rereq", 64'({bus.o_tx_reset, bus.o_tx_rst_ack}), 64'h0020_0000);
        tick(H);
        check("tx5_reack", 64'(bus.o_tx_rst_ack), 64'h0020);
        drain();

        // Mid-operation reset with lanes in ACKED and WAIT_RDY.
        bus.i_cold_rst = 1'b1;
        bus.i_tx_rst   = '1;
        tick(H + 1);
        bus.i_cold_rst = 1'b0;
        tick(2);
        rst_n = 1'b0;
        tick(1);
        check("mrst_outs", 64'({bus.o_tx_reset, bus.o_rx_reset, bus.o_tx_rst_ack, bus.o_rx_rst_ack}), 64'd0);
        bus.i_tx_rst = '0;
        rst_n = 1'b1;
        tick(5);
        check("mrst_quiet", 64'({bus.o_tx_reset, bus.o_rx_reset, bus.o_tx_rst_ack, bus.o_rx_rst_ack}), 64'd0);

        // Randomized traffic; some lanes never report ready in a given segment.
        cold_on = 1'b0;
        for (int seg = 0; seg < 8; seg++) begin
            dead = NL'({$urandom, $urandom}) & NL'({$urandom, $urandom});
            if (seg == 5) begin
                rst_n = 1'b0;
                tick(2);
                rst_n = 1'b1;
            end
            for (int c = 0; c < 500; c++) begin
                rand_drive(dead, cold_on);
                tick(1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
